// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, optional skid entry,
// flush-to-bubble, qualified regwrite and a saturating stall counter.
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwrite,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwrite,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              in_ready_s;
    logic              in_ready_nxt_s;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] out_data_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_s;
    logic              out_rw_r;
    logic              out_rw_s;
    logic              skid_rw_r;
    logic              skid_rw_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Ready source: registered with a skid entry, otherwise pass-through of downstream ready.
    always_comb begin
        in_ready_s = 1'b0;
        if (SKID != 0) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = out_ready | ~out_valid_r;
        end
    end

    assign in_xfer_s  = in_valid & in_ready_s;
    assign out_xfer_s = out_valid_r & out_ready;

    // Next-state and datapath steering; regwrite bits are cleared whenever an entry empties.
    always_comb begin
        state_s     = state_r;
        out_data_s  = out_data_r;
        skid_data_s = skid_data_r;
        out_rw_s    = out_rw_r;
        skid_rw_s   = skid_rw_r;
        if (flush) begin
            state_s   = ST_EMPTY;
            out_rw_s  = 1'b0;
            skid_rw_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_s    = ST_ONE;
                        out_data_s = in_data;
                        out_rw_s   = in_regwrite;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        out_data_s = in_data;
                        out_rw_s   = in_regwrite;
                    end else if (in_xfer_s) begin
                        state_s     = ST_FULL;
                        skid_data_s = in_data;
                        skid_rw_s   = in_regwrite;
                    end else if (out_xfer_s) begin
                        state_s  = ST_EMPTY;
                        out_rw_s = 1'b0;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        state_s    = ST_ONE;
                        out_data_s = skid_data_r;
                        out_rw_s   = skid_rw_r;
                        skid_rw_s  = 1'b0;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s   = ST_EMPTY;
                    out_rw_s  = 1'b0;
                    skid_rw_s = 1'b0;
                end
            endcase
        end
    end

    // Registered ready looks ahead at the next occupancy so out_ready never reaches in_ready.
    always_comb begin
        in_ready_nxt_s = 1'b1;
        if (flush) begin
            in_ready_nxt_s = 1'b1;
        end else begin
            in_ready_nxt_s = (state_s != ST_FULL);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_rw_r    <= 1'b0;
            skid_rw_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= in_ready_nxt_s;
            out_rw_r    <= out_rw_s;
            skid_rw_r   <= skid_rw_s;
        end
    end

    // Payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {DATA_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            out_data_r  <= out_data_s;
            skid_data_r <= skid_data_s;
        end
    end

    // Stall counter saturates at all-ones and survives flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_regwrite = out_rw_r;
    assign occupancy    = state_r;
    assign stall_count  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid build, CNT_W=4 build and SKID=0 build.
module tb_pipe_stage_buf;

    localparam int DW = 128;

    typedef struct {
        logic [DW-1:0] d;
        logic          rw;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t mq[$];
    exp_t zq[$];

    logic m_in_valid, m_in_ready, m_in_rw, m_flush, m_out_valid, m_out_ready, m_out_regwrite;
    logic [DW-1:0] m_in_data, m_out_data;
    logic [1:0] m_occupancy;
    logic [15:0] m_stall;

    logic s_in_valid, s_in_ready, s_in_rw, s_flush, s_out_valid, s_out_ready, s_out_regwrite;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [1:0] s_occupancy;
    logic [3:0] s_stall;

    logic z_in_valid, z_in_ready, z_in_rw, z_flush, z_out_valid, z_out_ready, z_out_regwrite;
    logic [DW-1:0] z_in_data, z_out_data;
    logic [1:0] z_occupancy;
    logic [15:0] z_stall;

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_data(m_in_data), .in_regwrite(m_in_rw), .flush(m_flush),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .out_regwrite(m_out_regwrite), .occupancy(m_occupancy), .stall_count(m_stall)
    );

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_regwrite(s_in_rw), .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_regwrite(s_out_regwrite), .occupancy(s_occupancy), .stall_count(s_stall)
    );

    pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_data(z_in_data), .in_regwrite(z_in_rw), .flush(z_flush),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .out_regwrite(z_out_regwrite), .occupancy(z_occupancy), .stall_count(z_stall)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one payload on the main instance and record its expected output.
    task automatic send_m(input logic [DW-1:0] d, input logic rw, input bit lat);
        int n;
        m_in_data  = d;
        m_in_rw    = rw;
        m_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL m_send_timeout: got in_ready=0 expected 1 for data %0h", d);
        end else begin
            mq.push_back('{d: d, rw: rw, c: (lat ? cyc + 1 : -1)});
        end
        tick();
        m_in_valid = 1'b0;
    endtask

    // Main-instance monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) chk("m_rw_bubble", {{(DW-1){1'b0}}, m_out_regwrite & ~m_out_valid}, '0);
        if (rst_n && m_out_valid && m_out_ready) begin
            if (mq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_extra_out: got data %0h expected no output", m_out_data);
            end else begin
                e = mq.pop_front();
                chk("m_data", m_out_data, e.d);
                chk("m_regwrite", {{(DW-1){1'b0}}, m_out_regwrite}, {{(DW-1){1'b0}}, e.rw});
                if (e.c >= 0) chk("m_latency", cyc, e.c);
            end
        end
    end

    // SKID=0 monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && z_out_valid && z_out_ready) begin
            if (zq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL z_extra_out: got data %0h expected no output", z_out_data);
            end else begin
                e = zq.pop_front();
                chk("z_data", z_out_data, e.d);
                chk("z_regwrite", {{(DW-1){1'b0}}, z_out_regwrite}, {{(DW-1){1'b0}}, e.rw});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int zi;
        logic fm;
        logic acc;
        logic exp_ir;
        m_in_valid = 1'b0; m_in_data = '0; m_in_rw = 1'b0; m_flush = 1'b0; m_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_rw = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        z_in_valid = 1'b0; z_in_data = '0; z_in_rw = 1'b0; z_flush = 1'b0; z_out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_occupancy", m_occupancy, 0);
        chk("rst_out_data", m_out_data, 0);
        chk("rst_regwrite", m_out_regwrite, 0);
        chk("rst_stall", m_stall, 0);
        chk("rst_in_ready", m_in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Streaming at full throughput, one-cycle latency
        for (int i = 1; i <= 5; i++) send_m(i, i[0], 1'b1);
        repeat (3) tick();
        @(negedge clk);
        chk("stream_stall", m_stall, 0);
        chk("stream_drained", mq.size(), 0);

        // Backpressure into the skid entry
        tick();
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_data = 'hA; m_in_rw = 1'b1;
        @(negedge clk);
        chk("bp_ir0", m_in_ready, 1);
        mq.push_back('{d: 'hA, rw: 1'b1, c: -1});
        tick();
        m_in_data = 'hB; m_in_rw = 1'b0;
        @(negedge clk);
        chk("bp_occ1", m_occupancy, 1);
        chk("bp_ir1", m_in_ready, 1);
        mq.push_back('{d: 'hB, rw: 1'b0, c: -1});
        tick();
        m_in_data = 'hC; m_in_rw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_occ2", m_occupancy, 2);
            chk("bp_ir_full", m_in_ready, 0);
            tick();
        end
        m_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ir_release0", m_in_ready, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_in_ready && n < 20);
        chk("bp_ir_release1", n, 1);
        if (m_in_ready) mq.push_back('{d: 'hC, rw: 1'b1, c: -1});
        tick();
        m_in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("bp_stall", m_stall, 5);
        chk("bp_drained", mq.size(), 0);

        // Flush while FULL with a simultaneous in_valid
        tick();
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_data = 'hE; m_in_rw = 1'b1;
        @(negedge clk);
        tick();
        m_in_data = 'hF;
        @(negedge clk);
        chk("fl_occ1", m_occupancy, 1);
        tick();
        m_in_data = 'hD; m_flush = 1'b1;
        @(negedge clk);
        chk("fl_occ2", m_occupancy, 2);
        tick();
        m_flush = 1'b0; m_in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", m_out_valid, 0);
        chk("fl_occ0", m_occupancy, 0);
        chk("fl_regwrite", m_out_regwrite, 0);
        chk("fl_in_ready", m_in_ready, 1);
        tick();
        m_out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("fl_stall", m_stall, 7);

        // Flush discards an accepted payload while empty
        tick();
        m_in_valid = 1'b1; m_in_data = 'h77; m_in_rw = 1'b1; m_flush = 1'b1;
        @(negedge clk);
        chk("fle_in_ready", m_in_ready, 1);
        tick();
        m_flush = 1'b0; m_in_valid = 1'b0;
        @(negedge clk);
        chk("fle_out_valid", m_out_valid, 0);
        chk("fle_occ", m_occupancy, 0);

        // Async reset between edges while FULL
        tick();
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_data = 'h55; m_in_rw = 1'b1;
        tick();
        m_in_data = 'h66;
        tick();
        m_in_valid = 1'b0;
        @(negedge clk);
        chk("ar_occ2", m_occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", m_out_valid, 0);
        chk("ar_occ", m_occupancy, 0);
        chk("ar_out_data", m_out_data, 0);
        chk("ar_regwrite", m_out_regwrite, 0);
        chk("ar_stall", m_stall, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_out_ready = 1'b1;
        @(negedge clk);
        chk("ar_in_ready", m_in_ready, 1);
        chk("ar_stall_post", m_stall, 0);
        chk("ar_out_valid_post", m_out_valid, 0);
        tick();
        send_m('h21, 1'b1, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        chk("ar_drained", mq.size(), 0);

        // Stall counter saturation with CNT_W=4
        tick();
        s_in_valid = 1'b1; s_in_data = 'h1; s_in_rw = 1'b1;
        @(negedge clk);
        tick();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 6) chk("sat_5", s_stall, 5);
            if (i == 16) chk("sat_15", s_stall, 15);
            if (i == 22) begin
                chk("sat_hold", s_stall, 15);
                chk("sat_valid", s_out_valid, 1);
            end
        end

        // SKID=0: toggling out_ready, 10 payloads
        tick();
        fm = 1'b0;
        zi = 0;
        z_in_valid = 1'b1; z_in_data = 'h100; z_in_rw = 1'b0;
        for (int c = 0; c < 40 && zi < 10; c++) begin
            z_out_ready = (c % 2 == 0);
            @(negedge clk);
            exp_ir = z_out_ready | ~fm;
            chk("z_in_ready", z_in_ready, exp_ir);
            chk("z_occ", z_occupancy, fm);
            acc = z_in_valid & exp_ir;
            if (acc) begin
                zq.push_back('{d: z_in_data, rw: z_in_rw, c: -1});
                zi++;
            end
            tick();
            fm = acc | (fm & ~z_out_ready);
            if (acc) begin
                if (zi < 10) begin
                    z_in_data = 'h100 + zi;
                    z_in_rw = zi[0];
                end else begin
                    z_in_valid = 1'b0;
                end
            end
        end
        z_in_valid = 1'b0;
        z_out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("z_count", zi, 10);
        chk("z_drained", zq.size(), 0);
        chk("z_occ_end", z_occupancy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
